// File: rtl/dir_pkg.sv
// Shared encodings for the directory request scheduler: MSI directory states,
// coherence op codes, scheduler FSM states and sharer-vector bit positions.
package dir_pkg;

  typedef enum logic [2:0] {
    DIR_EMPTY = 3'b000,
    DIR_I     = 3'b001,
    DIR_S     = 3'b010,
    DIR_M     = 3'b011
  } msi_e;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_GETS = 2'b01,
    OP_GETM = 2'b10,
    OP_PUTM = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_CHECK,
    ST_RECALL,
    ST_INVAL,
    ST_MEMRD,
    ST_MEMWR,
    ST_FINISH
  } state_e;

  localparam int unsigned P0_BIT = 0;
  localparam int unsigned P1_BIT = 1;

  // One-hot sharer vector for a requester index (0 = P0, 1 = P1).
  function automatic logic [1:0] req_bit(input logic p);
    logic [1:0] v;
    v = '0;
    if (p) v[P1_BIT] = 1'b1;
    else   v[P0_BIT] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dir_request_scheduler_if.sv
// Request, directory, recall/invalidate and memory signals of the scheduler.
// slave = scheduler side, master = processor/directory/memory side.
interface dir_request_scheduler_if;
  logic       ReqP0, ReqP1;
  logic [1:0] OpP0, OpP1;
  logic [3:0] AddrP0, AddrP1;
  logic [3:0] DataP0, DataP1;
  logic       GntP0, GntP1;
  logic       DoneP0, DoneP1;
  logic [3:0] RespData;
  logic       DirLookup;
  logic [3:0] DirAddr;
  logic [2:0] DirState;
  logic [1:0] DirSharers;
  logic       DirWe;
  logic [2:0] DirNewState;
  logic [1:0] DirNewSharers;
  logic       RecallP0, RecallP1, RecallExcl, RecallAck;
  logic [3:0] RecallData;
  logic       InvP0, InvP1, InvAck;
  logic       MemReq, MemWe;
  logic [3:0] MemAddr, MemWData;
  logic       MemAck;
  logic [3:0] MemRdData;

  modport slave (
    input  ReqP0, ReqP1, OpP0, OpP1, AddrP0, AddrP1, DataP0, DataP1,
           DirState, DirSharers, RecallAck, RecallData, InvAck, MemAck, MemRdData,
    output GntP0, GntP1, DoneP0, DoneP1, RespData, DirLookup, DirAddr,
           DirWe, DirNewState, DirNewSharers, RecallP0, RecallP1, RecallExcl,
           InvP0, InvP1, MemReq, MemWe, MemAddr, MemWData
  );

  modport master (
    output ReqP0, ReqP1, OpP0, OpP1, AddrP0, AddrP1, DataP0, DataP1,
           DirState, DirSharers, RecallAck, RecallData, InvAck, MemAck, MemRdData,
    input  GntP0, GntP1, DoneP0, DoneP1, RespData, DirLookup, DirAddr,
           DirWe, DirNewState, DirNewSharers, RecallP0, RecallP1, RecallExcl,
           InvP0, InvP1, MemReq, MemWe, MemAddr, MemWData
  );
endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; the pointer remembers the last winner and
// only moves when a grant is actually issued.
module rr_arbiter_2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt
);

  // r_last = 1 means P1 won last, so P0 is favoured out of reset
  logic r_last;

  always_comb begin
    o_gnt    = '0;
    o_gnt[0] = i_en && i_req[0] && (!i_req[1] || r_last);
    o_gnt[1] = i_en && i_req[1] && (!i_req[0] || !r_last);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)       r_last <= 1'b1;
    else if (|o_gnt) r_last <= o_gnt[1];
  end

endmodule

// File: rtl/dir_request_scheduler.sv
// Single-transaction MSI coherence sequencer between two L1 controllers and
// the shared directory / main memory.
module dir_request_scheduler
  import dir_pkg::*;
(
  input logic                   Clock,
  input logic                   Reset,
  dir_request_scheduler_if.slave bus
);

  state_e     r_state, w_next;
  logic       r_req;
  op_e        r_op;
  logic [3:0] r_addr, r_data, r_resp, r_memwdata;
  logic [1:0] r_old_sh;
  logic       r_drop;

  logic [1:0] w_valid, w_gnt;
  logic       w_own, w_oth, w_drop;

  assign w_valid = {bus.ReqP1 && (bus.OpP1 != OP_NONE),
                    bus.ReqP0 && (bus.OpP0 != OP_NONE)};

  rr_arbiter_2 u_arb (
    .i_clk (Clock),
    .i_rst (Reset),
    .i_req (w_valid),
    .i_en  (r_state == ST_IDLE),
    .o_gnt (w_gnt)
  );

  assign w_own  = bus.DirSharers[r_req];
  assign w_oth  = bus.DirSharers[~r_req];
  assign w_drop = (r_op == OP_PUTM) && !((bus.DirState == DIR_M) && w_own);

  always_ff @(posedge Clock) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_req      <= 1'b0;
      r_op       <= OP_NONE;
      r_addr     <= '0;
      r_data     <= '0;
      r_resp     <= '0;
      r_memwdata <= '0;
      r_old_sh   <= '0;
      r_drop     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (|w_gnt) begin
          r_req  <= w_gnt[1];
          r_op   <= op_e'(w_gnt[1] ? bus.OpP1 : bus.OpP0);
          r_addr <= w_gnt[1] ? bus.AddrP1 : bus.AddrP0;
          r_data <= w_gnt[1] ? bus.DataP1 : bus.DataP0;
          r_resp <= '0;
          r_drop <= 1'b0;
        end
        ST_CHECK: begin
          r_old_sh <= bus.DirSharers;
          r_drop   <= w_drop;
          if (r_op == OP_PUTM) r_memwdata <= r_data;
        end
        // Recalled dirty data is both the reply and the memory writeback
        ST_RECALL: if (bus.RecallAck) begin
          r_resp     <= bus.RecallData;
          r_memwdata <= bus.RecallData;
        end
        ST_MEMRD: if (bus.MemAck) r_resp <= bus.MemRdData;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next            = r_state;
    bus.GntP0         = w_gnt[0];
    bus.GntP1         = w_gnt[1];
    bus.DoneP0        = 1'b0;
    bus.DoneP1        = 1'b0;
    bus.RespData      = '0;
    bus.DirLookup     = 1'b0;
    bus.DirAddr       = r_addr;
    bus.DirWe         = 1'b0;
    bus.DirNewState   = '0;
    bus.DirNewSharers = '0;
    bus.RecallP0      = 1'b0;
    bus.RecallP1      = 1'b0;
    bus.RecallExcl    = 1'b0;
    bus.InvP0         = 1'b0;
    bus.InvP1         = 1'b0;
    bus.MemReq        = 1'b0;
    bus.MemWe         = 1'b0;
    bus.MemAddr       = r_addr;
    bus.MemWData      = '0;
    case (r_state)
      ST_IDLE:   if (|w_gnt) w_next = ST_LOOKUP;
      ST_LOOKUP: begin
        bus.DirLookup = 1'b1;
        w_next        = ST_CHECK;
      end
      ST_CHECK: begin
        if (r_op == OP_PUTM)                                       w_next = w_drop ? ST_FINISH : ST_MEMWR;
        else if ((bus.DirState == DIR_M) && w_oth)                 w_next = ST_RECALL;
        else if ((r_op == OP_GETM) && (bus.DirState == DIR_S) && w_oth) w_next = ST_INVAL;
        else                                                       w_next = ST_MEMRD;
      end
      ST_RECALL: begin
        bus.RecallP0   = r_req;
        bus.RecallP1   = !r_req;
        bus.RecallExcl = (r_op == OP_GETM);
        if (bus.RecallAck) w_next = ST_MEMWR;
      end
      ST_INVAL: begin
        bus.InvP0 = r_req;
        bus.InvP1 = !r_req;
        if (bus.InvAck) w_next = ST_MEMRD;
      end
      ST_MEMRD: begin
        bus.MemReq = 1'b1;
        if (bus.MemAck) w_next = ST_FINISH;
      end
      ST_MEMWR: begin
        bus.MemReq   = 1'b1;
        bus.MemWe    = 1'b1;
        bus.MemWData = r_memwdata;
        if (bus.MemAck) w_next = ST_FINISH;
      end
      ST_FINISH: begin
        bus.DoneP0   = !r_req;
        bus.DoneP1   = r_req;
        bus.RespData = r_resp;
        if (!r_drop) begin
          bus.DirWe = 1'b1;
          case (r_op)
            OP_GETS: begin
              bus.DirNewState   = DIR_S;
              bus.DirNewSharers = r_old_sh | req_bit(r_req);
            end
            OP_GETM: begin
              bus.DirNewState   = DIR_M;
              bus.DirNewSharers = req_bit(r_req);
            end
            default: begin
              bus.DirNewState   = DIR_I;
              bus.DirNewSharers = '0;
            end
          endcase
        end
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

// File: doc/dir_request_scheduler.md
# dir_request_scheduler

Serializes coherence requests from the two L1 cache controllers onto the shared directory list and main memory. Arbitrates round-robin between P0 and P1, looks up the directory entry, sequences recall/invalidate/memory phases of the MSI protocol, replies to the requester and writes the updated directory entry. Sits between the processor blocks and the directory/memory blocks; exactly one transaction is in flight at a time.

## Interface
- No parameters; all widths fixed by the 4-bit address/data and 3-bit state encodings.
- Clock  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high
- ReqP0 / ReqP1  in  1  request pending; held until DoneP0/P1
- OpP0 / OpP1  in  2  01 GetS (read miss), 10 GetM (write miss), 11 PutM (writeback), 00 ignored
- AddrP0 / AddrP1  in  4  block address code (0001..1000)
- DataP0 / DataP1  in  4  writeback data (PutM only)
- GntP0 / GntP1  out  1  one-cycle grant pulse
- DoneP0 / DoneP1  out  1  one-cycle completion pulse
- RespData  out  4  reply data, valid with Done
- DirLookup  out  1  one-cycle directory read strobe
- DirAddr  out  4  directory address (latched request address)
- DirState  in  3  entry state, valid cycle after DirLookup (000 empty, 001 I, 010 S, 011 M)
- DirSharers  in  2  sharer/owner vector, bit0 = P0, bit1 = P1
- DirWe  out  1  one-cycle directory update strobe
- DirNewState  out  3  state written with DirWe
- DirNewSharers  out  2  sharers written with DirWe
- RecallP0 / RecallP1  out  1  fetch block from M owner; held until RecallAck
- RecallExcl  out  1  1: owner invalidates; 0: owner downgrades to S
- RecallAck  in  1  owner done; RecallData valid same cycle
- RecallData  in  4  owner's dirty data
- InvP0 / InvP1  out  1  invalidate sharer copy; held until InvAck
- InvAck  in  1  invalidate acknowledged
- MemReq  out  1  memory request; held until MemAck
- MemWe  out  1  1 write, 0 read; stable while MemReq
- MemAddr / MemWData  out  4  memory address / write data
- MemAck  in  1  memory done; MemRdData valid same cycle
- MemRdData  in  4  read data

## Operation
- States: IDLE, LOOKUP, CHECK, RECALL, INVAL, MEMRD, MEMWR, FINISH.
- IDLE: if any Req with Op≠00, select via round-robin, latch requester/op/addr/data, pulse Gnt -> LOOKUP. Op=00 requests never granted.
- Round-robin: both requesting -> grant the one not granted last; pointer updates on grant only; after reset P0 has priority.
- LOOKUP: pulse DirLookup -> CHECK.
- CHECK, evaluated in order (other = non-requester):
  - PutM, requester not owner (state≠011 or own bit clear): drop -> FINISH without DirWe.
  - PutM, valid: MemWData = latched data -> MEMWR.
  - GetS/GetM, state 011, other bit set -> RECALL (RecallExcl = GetM).
  - GetM, state 010, other bit set -> INVAL.
  - otherwise -> MEMRD.
- RECALL: assert Recall<other> until RecallAck; latch RecallData as reply and MemWData -> MEMWR.
- INVAL: assert Inv<other> until InvAck -> MEMRD.
- MEMRD: MemReq, MemWe=0 until MemAck; latch MemRdData as reply -> FINISH.
- MEMWR: MemReq, MemWe=1 until MemAck -> FINISH.
- FINISH (one cycle): pulse Done<req>, drive RespData; pulse DirWe unless dropped PutM:
  - GetS: 010, sharers = old | req bit (recalled owner stays as sharer).
  - GetM: 011, sharers = req bit only.
  - PutM: 001, sharers = 00.
  - then -> IDLE.

## Timing
- Reset: state IDLE, every output 0, RR pointer favouring P0, latched fields 0. Reset mid-transaction aborts it; no Done, no DirWe.
- Zero-wait GetS/GetM clean: Req sampled cycle 0 (Gnt), DirLookup cycle 1, CHECK cycle 2, MemReq cycle 3 with MemAck, Done + DirWe cycle 4.
- Each handshake phase lasts ≥1 cycle; Ack sampled while its request is high; Acks in other states ignored.
- Request arriving while busy waits; Req dropped before Gnt is not serviced.
- Next grant no earlier than the cycle after FINISH.

## Structure
- Package dir_pkg: MSI state codes (EMPTY/I/S/M), op codes, FSM state enum, sharer-bit indices.
- Sub-module rr_arbiter_2: 2-way round-robin with grant-enable and pointer register.

## Test plan
- Reset, both idle: all outputs 0; ReqP1 GetS addr 0011, MemRdData 0101 -> GntP1 cycle 0, DoneP1 cycle 4, RespData 0101, DirNewState 010, sharers 10.
- ReqP0 and ReqP1 same cycle, both GetS: P0 granted first, P1 next; repeated contention alternates.
- P0 GetM addr 0001, directory 010/sharers 11 -> InvP1 held until InvAck, then memory read; FINISH writes 011/01.
- P1 GetS, directory 011/sharers 01 -> RecallP0, RecallExcl 0; RecallData 0110 -> memory write 0110, RespData 0110, dir 010/11.
- P0 PutM data 1001 with dir 011/01 -> MemWe 1 data 1001, dir 001/00; P1 PutM same entry -> Done, no MemReq, no DirWe.
- Reset asserted during RECALL: next cycle outputs all 0, state IDLE, no Done.
